// File: rtl/fifo_stat_if.sv
// Handshake and status bundle between a FIFO user and fifo_stat.
// master drives push/pop/flush; slave (the FIFO) drives data and status.
interface fifo_stat_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              clr;
  logic              wr;
  logic [DATA_W-1:0] wr_data;
  logic              rd;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              udf;

  modport master (
    output clr, wr, wr_data, rd,
    input  rd_data, full, empty, almost_full, almost_empty, count, ovf, udf
  );

  modport slave (
    input  clr, wr, wr_data, rd,
    output rd_data, full, empty, almost_full, almost_empty, count, ovf, udf
  );
endinterface

// File: rtl/fifo_stat.sv
// Synchronous show-ahead FIFO with occupancy count, almost flags and
// sticky overflow/underflow flags.
module fifo_stat #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  fifo_stat_if.slave  bus
);
  localparam logic [ADDR_W:0] AF_C = AF_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C = AE_LVL[ADDR_W:0];

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;
  logic              r_udf;

  logic w_full;
  logic w_empty;
  logic w_do_wr;
  logic w_do_rd;
  logic w_set_ovf;
  logic w_set_udf;

  // count never exceeds 2**ADDR_W, so its MSB alone marks full
  assign w_full  = r_count[ADDR_W];
  assign w_empty = (r_count == '0);

  // When full, a simultaneous pop frees the slot the push lands in
  assign w_do_wr   = ~bus.clr & bus.wr & (~w_full | bus.rd);
  assign w_do_rd   = ~bus.clr & bus.rd & ~w_empty;
  assign w_set_ovf = ~bus.clr & bus.wr & ~bus.rd & w_full;
  assign w_set_udf = ~bus.clr & bus.rd & w_empty;

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (bus.clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_udf) r_udf <= 1'b1;
    end
  end

  assign bus.rd_data      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= AF_C);
  assign bus.almost_empty = (r_count <= AE_C);
  assign bus.count        = r_count;
  assign bus.ovf          = r_ovf;
  assign bus.udf          = r_udf;
endmodule

// File: tb/tb_fifo_stat.sv
// Directed self-checking bench for fifo_stat: fill/drain, error flags,
// simultaneous push/pop, pointer wrap and asynchronous reset.
module tb_fifo_stat;
  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;
  logic [7:0] sb [$];
  logic [7:0] d;

  fifo_stat_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  fifo_stat #(.DATA_W(8), .ADDR_W(4), .AF_LVL(12), .AE_LVL(4)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock with the given request; inputs released 1 time unit after the edge
  task automatic op(input logic w, input logic r, input logic c, input logic [7:0] data);
    bus.wr      = w;
    bus.rd      = r;
    bus.clr     = c;
    bus.wr_data = data;
    @(posedge clk);
    #1;
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    bus.clr = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0; bus.wr_data = 8'h00;
    #12;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_af", bus.almost_full, 0);
    chk("rst_ae", bus.almost_empty, 1);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_udf", bus.udf, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      op(1'b1, 1'b0, 1'b0, 8'(i));
      chk("fill_count", bus.count, i);
      chk("fill_rd_data", bus.rd_data, 8'h01);
      chk("fill_af", bus.almost_full, (i >= 12) ? 1 : 0);
      chk("fill_full", bus.full, (i == 16) ? 1 : 0);
      chk("fill_ae", bus.almost_empty, (i <= 4) ? 1 : 0);
      chk("fill_empty", bus.empty, 0);
    end

    op(1'b1, 1'b0, 1'b0, 8'hAA);
    chk("ovf_set", bus.ovf, 1);
    chk("ovf_count", bus.count, 16);
    chk("ovf_head", bus.rd_data, 8'h01);
    chk("ovf_full", bus.full, 1);

    // drain
    for (int k = 0; k < 16; k++) begin
      chk("drain_head", bus.rd_data, k + 1);
      op(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_count", bus.count, 15 - k);
      chk("drain_ae", bus.almost_empty, (15 - k <= 4) ? 1 : 0);
      chk("drain_empty", bus.empty, (k == 15) ? 1 : 0);
      chk("drain_full", bus.full, 0);
    end
    chk("drain_rd_zero", bus.rd_data, 0);
    chk("drain_ovf_sticky", bus.ovf, 1);
    chk("drain_udf", bus.udf, 0);

    op(1'b0, 1'b1, 1'b0, 8'h00);
    chk("udf_set", bus.udf, 1);
    chk("udf_count", bus.count, 0);
    chk("udf_rd_zero", bus.rd_data, 0);

    op(1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr_ovf", bus.ovf, 0);
    chk("clr_udf", bus.udf, 0);
    chk("clr_count", bus.count, 0);

    // simultaneous on empty
    op(1'b1, 1'b1, 1'b0, 8'h55);
    chk("wr_rd_empty_count", bus.count, 1);
    chk("wr_rd_empty_rd_data", bus.rd_data, 8'h55);
    chk("wr_rd_empty_udf", bus.udf, 1);
    chk("wr_rd_empty_empty", bus.empty, 0);

    // clr ignores a concurrent push
    op(1'b1, 1'b0, 1'b1, 8'h99);
    chk("clr_wr_count", bus.count, 0);
    chk("clr_wr_udf", bus.udf, 0);

    for (int i = 1; i <= 16; i++) op(1'b1, 1'b0, 1'b0, 8'(i));
    chk("refill_full", bus.full, 1);
    op(1'b1, 1'b1, 1'b0, 8'h77);
    chk("wr_rd_full_count", bus.count, 16);
    chk("wr_rd_full_rd_data", bus.rd_data, 8'h02);
    chk("wr_rd_full_ovf", bus.ovf, 0);
    chk("wr_rd_full_full", bus.full, 1);
    for (int k = 0; k < 15; k++) begin
      chk("post_full_head", bus.rd_data, k + 2);
      op(1'b0, 1'b1, 1'b0, 8'h00);
    end
    chk("post_full_last", bus.rd_data, 8'h77);
    op(1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_full_empty", bus.empty, 1);

    // wrap-around with occupancy held in 1..5
    op(1'b0, 1'b0, 1'b1, 8'h00);
    op(1'b1, 1'b0, 1'b0, 8'hC0);
    sb.push_back(8'hC0);
    for (int i = 0; i < 40; i++) begin
      d = 8'(8'hC1 + i);
      if (i % 5 == 4) begin
        op(1'b1, 1'b1, 1'b0, d);
        void'(sb.pop_front());
        sb.push_back(d);
      end else if (sb.size() == 1 || (sb.size() < 5 && i % 3 != 0)) begin
        op(1'b1, 1'b0, 1'b0, d);
        sb.push_back(d);
      end else begin
        op(1'b0, 1'b1, 1'b0, 8'h00);
        void'(sb.pop_front());
      end
      chk("wrap_rd_data", bus.rd_data, sb[0]);
      chk("wrap_count", bus.count, sb.size());
      chk("wrap_ae", bus.almost_empty, (sb.size() <= 4) ? 1 : 0);
      chk("wrap_flags", {bus.full, bus.empty, bus.almost_full, bus.ovf, bus.udf}, 0);
    end

    // async reset mid-stream
    op(1'b0, 1'b0, 1'b1, 8'h00);
    op(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) op(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    chk("pre_rst_count", bus.count, 7);
    chk("pre_rst_udf", bus.udf, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", bus.count, 0);
    chk("async_rst_empty", bus.empty, 1);
    chk("async_rst_rd_data", bus.rd_data, 0);
    chk("async_rst_udf", bus.udf, 0);
    chk("async_rst_ae", bus.almost_empty, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    op(1'b1, 1'b0, 1'b0, 8'h3C);
    chk("post_rst_rd_data", bus.rd_data, 8'h3C);
    chk("post_rst_count", bus.count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
